// File: rtl/jtframe_db15_pkg.sv
// Shared types and constants for the DB15 joystick reader (74HC165 chain, two players).
// The state encoding and bit map are used by jtframe_db15_joy and jtframe_db15_deb.
package jtframe_db15_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } db15_state_e;

  // Per-player bit positions inside each 12-bit field
  localparam int RIGHT = 0;
  localparam int LEFT  = 1;
  localparam int DOWN  = 2;
  localparam int UP    = 3;
  localparam int BUT1  = 4;
  localparam int BUT2  = 5;
  localparam int BUT3  = 6;
  localparam int BUT4  = 7;
  localparam int BUT5  = 8;
  localparam int BUT6  = 9;
  localparam int START = 10;
  localparam int COIN  = 11;

  localparam int PLAYER_BITS = 12;
  localparam int FRAME_BITS  = 2 * PLAYER_BITS;
  localparam int LOAD_TICKS  = 2;

  // The chain reads all-low when no joystick board is plugged in, which
  // shows up as all ones after inversion.
  function automatic logic is_disconnected(input logic [FRAME_BITS-1:0] inv_raw);
    return &inv_raw;
  endfunction

endpackage

// File: rtl/jtframe_db15_deb.sv
// Per-bit two-frame debouncer: an output bit follows its input only after two
// consecutive enabled samples agree; clr drops both outputs and history to zero.
module jtframe_db15_deb
  import jtframe_db15_pkg::*;
#(
  parameter int W = FRAME_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] hist;
  logic [W-1:0] agree;

  assign agree = ~(d ^ hist);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      q    <= '0;
    end else if (en) begin
      if (clr) begin
        hist <= '0;
        q    <= '0;
      end else begin
        hist <= d;
        q    <= (agree & d) | (~agree & q);
      end
    end
  end

endmodule

// File: rtl/jtframe_db15_joy.sv
// Reads two DB15 arcade joysticks through a 24-bit 74HC165 chain and publishes
// active-high words per player with an update strobe. Define
// JTFRAME_DB15_DEBOUNCE_EN to add a two-frame debouncer on every bit.
module jtframe_db15_joy
  import jtframe_db15_pkg::*;
#(
  parameter int CLKDIV     = 8,
  parameter int POLL_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] board_joy1,
  output logic [15:0] board_joy2,
  output logic        joy_present,
  output logic        upd
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int TW = $clog2(POLL_TICKS + LOAD_TICKS + 1);
  localparam int IW = $clog2(FRAME_BITS);

  logic [DW-1:0] div_cnt;
  logic          tick;

  logic [1:0]    data_sync;
  logic          data_s;

  db15_state_e   st, st_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          joy_clk_nx, joy_load_nx;
  logic          sample;

  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  done;
  logic                  disc;

  // Free-running divider; a tick marks every half period of the shift clock
  assign tick = (div_cnt == DW'(CLKDIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_sync <= 2'b11;
    else        data_sync <= {data_sync[0], joy_data};
  end
  assign data_s = data_sync[1];

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    st_nx       = st;
    tcnt_nx     = tcnt;
    idx_nx      = idx;
    joy_clk_nx  = joy_clk;
    joy_load_nx = joy_load;
    sample      = 1'b0;
    case (st)
      IDLE: if (tick) begin
        if (tcnt == TW'(POLL_TICKS - 1)) begin
          st_nx       = LOAD;
          tcnt_nx     = '0;
          joy_load_nx = 1'b0;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      LOAD: if (tick) begin
        if (tcnt == TW'(LOAD_TICKS - 1)) begin
          st_nx       = SHIFT;
          tcnt_nx     = '0;
          idx_nx      = '0;
          joy_load_nx = 1'b1;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      SHIFT: if (tick) begin
        if (!joy_clk) begin
          // Data is sampled just before the rising edge shifts the chain
          sample     = 1'b1;
          joy_clk_nx = 1'b1;
        end else begin
          joy_clk_nx = 1'b0;
          if (idx == IW'(FRAME_BITS - 1)) st_nx  = DONE;
          else                            idx_nx = idx + IW'(1);
        end
      end
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      tcnt     <= '0;
      idx      <= '0;
      joy_clk  <= 1'b0;
      joy_load <= 1'b1;
    end else begin
      st       <= st_nx;
      tcnt     <= tcnt_nx;
      idx      <= idx_nx;
      joy_clk  <= joy_clk_nx;
      joy_load <= joy_load_nx;
    end
  end

  // Holds inverted (active-high) chain bits; only read out in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      shreg      <= '0;
    else if (sample) shreg[idx] <= ~data_s;
  end

  assign done = (st == DONE);
  assign disc = is_disconnected(shreg);
  assign upd  = done;

`ifdef JTFRAME_DB15_DEBOUNCE_EN
  jtframe_db15_deb #(
    .W (FRAME_BITS)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (done),
    .clr   (disc),
    .d     (shreg),
    .q     (frame_q)
  );
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    frame_q <= '0;
    else if (done) frame_q <= disc ? '0 : shreg;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    joy_present <= 1'b0;
    else if (done) joy_present <= ~disc;
  end

  assign board_joy1 = {4'h0, frame_q[PLAYER_BITS-1:0]};
  assign board_joy2 = {4'h0, frame_q[FRAME_BITS-1:PLAYER_BITS]};

endmodule

// File: tb/tb_jtframe_db15_joy.sv
// Self-checking bench for jtframe_db15_joy: models the 74HC165 chain and scores
// every published frame against a queue of expected words.
module tb_jtframe_db15_joy;

  localparam int CLKDIV     = 4;
  localparam int POLL_TICKS = 4;
  localparam int BUDGET     = 2000;

  typedef struct packed {
    logic [15:0] j1;
    logic [15:0] j2;
    logic        present;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        joy_data;
  logic        joy_clk, joy_load;
  logic [15:0] board_joy1, board_joy2;
  logic        joy_present, upd;

  int tests_run = 0;
  int tests_failed = 0;

  logic [23:0] press = '0;
  logic [23:0] sr = '1;
  logic        tie_low = 1'b0;
  logic [23:0] m_hist = '0;
  logic [23:0] m_out = '0;
  exp_t        sb[$];

  int   clk_rises = 0;
  int   load_low = 0;
  logic jc_d = 1'b0;

  always #5 clk = ~clk;

  jtframe_db15_joy #(
    .CLKDIV     (CLKDIV),
    .POLL_TICKS (POLL_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .joy_data    (joy_data),
    .joy_clk     (joy_clk),
    .joy_load    (joy_load),
    .board_joy1  (board_joy1),
    .board_joy2  (board_joy2),
    .joy_present (joy_present),
    .upd         (upd)
  );

  // 74HC165 chain: parallel load while low, shift toward bit 0 on rising clock
  always @(posedge joy_clk or negedge joy_load) begin
    if (!joy_load) sr <= ~press;
    else           sr <= {1'b1, sr[23:1]};
  end
  assign joy_data = tie_low ? 1'b0 : sr[0];

  always @(negedge clk) begin
    if (joy_clk && !jc_d) clk_rises++;
    jc_d = joy_clk;
    if (!joy_load) load_low++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_hist = '0;
    m_out  = '0;
  endtask

  // Drives the press vector for the next frame and queues the expected result
  task automatic push_frame(input logic [23:0] p, input logic tied);
    logic disc;
    exp_t e;
    press   = p;
    tie_low = tied;
    disc    = tied || (p == 24'hFFFFFF);
    if (disc) begin
      m_out  = '0;
      m_hist = '0;
    end else begin
`ifdef JTFRAME_DB15_DEBOUNCE_EN
      for (int b = 0; b < 24; b++)
        if (p[b] == m_hist[b]) m_out[b] = p[b];
      m_hist = p;
`else
      m_out = p;
`endif
    end
    e.j1      = {4'h0, m_out[11:0]};
    e.j2      = {4'h0, m_out[23:12]};
    e.present = !disc;
    sb.push_back(e);
  endtask

  // Waits for upd, checks stability before it and its width, then scores outputs
  task automatic collect(input string name);
    logic [15:0] s1, s2;
    int   changes;
    bit   got;
    exp_t e;
    s1 = board_joy1;
    s2 = board_joy2;
    changes = 0;
    got = 0;
    for (int n = 0; n < BUDGET && !got; n++) begin
      @(negedge clk);
      if (upd) got = 1;
      else if (board_joy1 !== s1 || board_joy2 !== s2) changes++;
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s upd_timeout: no upd within %0d cycles", name, BUDGET);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    tests_run++;
    if (changes !== 0) begin
      tests_failed++;
      $display("FAIL %s stable: outputs changed %0d times between upd, required 0", name, changes);
    end
    @(negedge clk);
    tests_run++;
    if (upd !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s upd_width: upd=%b one cycle later, required 0", name, upd);
    end
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s scoreboard: upd with empty queue", name);
      return;
    end
    e = sb.pop_front();
    if (board_joy1 !== e.j1) begin
      tests_failed++;
      $display("FAIL %s board_joy1: got %h, required %h", name, board_joy1, e.j1);
    end
    tests_run++;
    if (board_joy2 !== e.j2) begin
      tests_failed++;
      $display("FAIL %s board_joy2: got %h, required %h", name, board_joy2, e.j2);
    end
    tests_run++;
    if (joy_present !== e.present) begin
      tests_failed++;
      $display("FAIL %s joy_present: got %b, required %b", name, joy_present, e.present);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({joy_clk, joy_load, upd, joy_present} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset ctrl: clk/load/upd/present=%b, required 0100",
               {joy_clk, joy_load, upd, joy_present});
    end
    tests_run++;
    if (board_joy1 !== 16'h0 || board_joy2 !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset outputs: joy1=%h joy2=%h, required 0000 0000", board_joy1, board_joy2);
    end
  endtask

  task automatic test_p1();
    push_frame(24'h000018, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    collect("p1_up_b1");
  endtask

  task automatic test_p2_timing();
    int c0, l0;
    c0 = clk_rises;
    l0 = load_low;
    push_frame(24'hC00000, 1'b0);
    collect("p2_start_coin");
    tests_run++;
    if (clk_rises - c0 !== 24) begin
      tests_failed++;
      $display("FAIL joy_clk_edges: got %0d rising edges, required 24", clk_rises - c0);
    end
    tests_run++;
    if (load_low - l0 !== 2 * CLKDIV) begin
      tests_failed++;
      $display("FAIL joy_load_low: got %0d cycles, required %0d", load_low - l0, 2 * CLKDIV);
    end
  endtask

  task automatic test_disconnect();
    push_frame(24'h000000, 1'b1);
    collect("disconnected");
    push_frame(24'h000001, 1'b0);
    collect("reconnected");
  endtask

  task automatic test_reset_mid();
    int r0, n;
    push_frame(24'h000100, 1'b0);
    collect("pre_reset");
    push_frame(24'h000200, 1'b0);
    r0 = clk_rises;
    n = 0;
    while (n < BUDGET && (clk_rises - r0 < 10 || joy_clk)) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= BUDGET) begin
      tests_failed++;
      $display("FAIL mid_reset_reach: idx 10 not reached in %0d cycles", BUDGET);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (board_joy1 !== 16'h0 || board_joy2 !== 16'h0 || joy_present !== 1'b0 ||
        joy_load !== 1'b1 || joy_clk !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_state: joy1=%h joy2=%h present=%b load=%b clk=%b, required 0 0 0 1 0",
               board_joy1, board_joy2, joy_present, joy_load, joy_clk);
    end
    sb.delete();
    model_reset();
    repeat (3) @(negedge clk);
    push_frame(24'h000200, 1'b0);
    rst_n = 1'b1;
    collect("post_reset");
  endtask

  task automatic test_debounce();
`ifdef JTFRAME_DB15_DEBOUNCE_EN
    push_frame(24'h000020, 1'b0);
    collect("deb_single");
    push_frame(24'h000000, 1'b0);
    collect("deb_release");
    push_frame(24'h000020, 1'b0);
    collect("deb_first");
    push_frame(24'h000020, 1'b0);
    collect("deb_second");
`else
    push_frame(24'h000020, 1'b0);
    collect("direct_b2");
`endif
    tests_run++;
    if (board_joy1 !== 16'h0020) begin
      tests_failed++;
      $display("FAIL b2_final: board_joy1=%h, required 0020", board_joy1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      push_frame(24'($urandom), 1'b0);
      collect($sformatf("frame_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_p1();
    test_p2_timing();
    test_disconnect();
    test_reset_mid();
    test_debounce();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
